// File: rtl/g_hamming_encoder_if.sv
// g_hamming_encoder_if -- handshake bundle for the SECDED Hamming encoder.
// Input side: dataIn/inValid/inReady.
// Output side: codeOut/outValid/outReady, plus zeroWord and wordCnt.
// Optional: injMask exists only when G_HAMMING_ENC_ERRINJ_EN is defined.
// p_codeSize must equal p_dataSize + ECC_bitsQnty(p_dataSize) + 1.
interface g_hamming_encoder_if #(
    parameter int p_dataSize = 10,
    parameter int p_codeSize = 15
);
    logic [p_dataSize-1:0] dataIn;
    logic                  inValid;
    logic                  inReady;
    logic [p_codeSize-1:0] codeOut;
    logic                  outValid;
    logic                  outReady;
    logic                  zeroWord;
    logic [31:0]           wordCnt;
`ifdef G_HAMMING_ENC_ERRINJ_EN
    logic [p_codeSize-1:0] injMask;

    modport master (
        output dataIn, inValid, outReady, injMask,
        input  inReady, codeOut, outValid, zeroWord, wordCnt
    );
    modport slave (
        input  dataIn, inValid, outReady, injMask,
        output inReady, codeOut, outValid, zeroWord, wordCnt
    );
`else
    modport master (
        output dataIn, inValid, outReady,
        input  inReady, codeOut, outValid, zeroWord, wordCnt
    );
    modport slave (
        input  dataIn, inValid, outReady,
        output inReady, codeOut, outValid, zeroWord, wordCnt
    );
`endif
endinterface

// File: rtl/g_hamming_encoder.sv
// g_hamming_encoder -- two-stage pipelined SECDED Hamming encoder.
//
// Codeword layout, with positions k = 1..p_codeSize-1 mapped to codeOut[k-1]:
//   - Power-of-two positions hold check bits.
//   - The remaining positions hold the data bits in ascending order.
//   - codeOut[p_codeSize-1] is overall (even) parity.
//
// Pipeline:
//   - Stage 1 holds the raw data word.
//   - Stage 2 holds the finished codeword.
//   - A stage loads whenever it is empty or its content leaves in the same
//     cycle, so the encoder sustains one word per clock.
//
// Optional feature, macro G_HAMMING_ENC_ERRINJ_EN:
//   - Adds the injMask input.
//   - injMask is XORed into the codeword as it enters stage 2.
package G_RD_PROJ_functions;
    // Smallest r with 2^r >= dataSize + r + 1 (Hamming check-bit count).
    function automatic int ECC_bitsQnty(input int dataSize);
        int r;
        r = 1;
        while ((1 << r) < dataSize + r + 1) r = r + 1;
        return r;
    endfunction
endpackage

module g_hamming_encoder #(
    parameter int p_dataSize          = 10,
    parameter int p_zeroWordDetection = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    g_hamming_encoder_if.slave    bus
);
    localparam int p_eccBitsQnty = G_RD_PROJ_functions::ECC_bitsQnty(p_dataSize);
    localparam int p_codeSize    = p_dataSize + p_eccBitsQnty + 1;

    // Stage 1: raw data word.
    logic                  r_s1_valid;
    logic [p_dataSize-1:0] r_s1_data;

    // Stage 2: finished codeword.
    logic                  r_s2_valid;
    logic [p_codeSize-1:0] r_code;
    logic                  r_zero;

    // Count of delivered codewords.
    logic [31:0]           r_word_cnt;

    logic                  w_s1_adv;
    logic                  w_s2_adv;
    logic [p_codeSize-1:0] w_code;
    logic [p_codeSize-1:0] w_inj;
    logic                  w_zero;

    // Builds the codeword in three passes:
    //   1. scatter the data bits into the non-power-of-two positions;
    //   2. fill each check bit from the positions it covers;
    //   3. close with overall parity.
    // NOTE: blocking assignments are correct here (and in always_comb): each
    // line must see the value written by the line before it.
    function automatic logic [p_codeSize-1:0] encode(input logic [p_dataSize-1:0] d);
        logic [p_codeSize-1:0] c;
        logic                  p;
        int                    j;
        c = '0;
        j = 0;
        for (int k = 1; k < p_codeSize; k++) begin
            if ((k & (k - 1)) != 0) begin
                c[k-1] = d[j];
                j++;
            end
        end
        for (int i = 0; i < p_eccBitsQnty; i++) begin
            p = 1'b0;
            for (int k = 1; k < p_codeSize; k++) begin
                if ((((k >> i) & 1) == 1) && ((k & (k - 1)) != 0)) p = p ^ c[k-1];
            end
            c[(1 << i) - 1] = p;
        end
        c[p_codeSize-1] = ^c[p_codeSize-2:0];
        return c;
    endfunction

    assign w_code = encode(r_s1_data);
    assign w_zero = (p_zeroWordDetection != 0) && (r_s1_data == '0);

`ifdef G_HAMMING_ENC_ERRINJ_EN
    assign w_inj = bus.injMask;
`else
    assign w_inj = '0;
`endif

    // Advance conditions: stage 2 empties on a downstream accept; stage 1
    // follows stage 2 when it is empty or its word moves on.
    always_comb begin
        w_s2_adv = !r_s2_valid || bus.outReady;
        w_s1_adv = !r_s1_valid || w_s2_adv;
    end

    // Stage 1 occupancy; reset empties it and drops any input in that cycle.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.inValid;
        end
    end

    // Stage 1 data capture on an input transfer.
    // NOTE: this data register has no reset. It is only observed while
    // r_s1_valid is set, and the valid bit is reset.
    always_ff @(posedge clk) begin
        if (w_s1_adv && bus.inValid) begin
            r_s1_data <= bus.dataIn;
        end
    end

    // Stage 2: capture the encoded word, with any injected error, when it advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_code     <= '0;
            r_zero     <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_code <= w_code ^ w_inj;
                r_zero <= w_zero;
            end
        end
    end

    // Delivered-word counter, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
        end else if (r_s2_valid && bus.outReady) begin
            r_word_cnt <= r_word_cnt + 32'd1;
        end
    end

    // Held at 1 while reset is asserted, so no upstream stall is seen then.
    assign bus.inReady  = w_s1_adv || !rst_n;
    assign bus.codeOut  = r_code;
    assign bus.outValid = r_s2_valid;
    assign bus.zeroWord = r_zero;
    assign bus.wordCnt  = r_word_cnt;

endmodule
